fifo_rd_arbiter: RTL and testbench
==================================

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameter N_PORTS, default 4: number of FIFO read sides arbitrated (2..8).
REQ-002 Parameter DATA_W, default 8: FIFO word width.
REQ-003 Parameter BURST_MAX, default 4: maximum words popped per grant (1..16).
REQ-004 clk_r  input  1  single read-domain clock; all logic on its rising edge.
REQ-005 rst_r  input  1  asynchronous, active-low reset.
REQ-006 arb_en  input  1  high: new grants permitted; low: no new grant, but the current burst finishes.
REQ-007 fifo_empty  input  N_PORTS  per-port empty flag from each FIFO read side.
REQ-008 fifo_rdata  input  N_PORTS*DATA_W  per-port head word, port p at bits [p*DATA_W +: DATA_W]; valid whenever that port is non-empty (fall-through).
REQ-009 fifo_r_en  output  N_PORTS  per-port pop strobe, combinational, at most one bit high.
REQ-010 out_data  output  DATA_W  registered output word.
REQ-011 out_src  output  clog2(N_PORTS)  index of the port that supplied out_data.
REQ-012 out_valid  output  1  out_data/out_src are valid.
REQ-013 out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-014 busy  output  1  high while in GRANT state.

Function
REQ-015 The FSM SHALL have two states: IDLE and GRANT; registers SHALL be grant index g, last-served index last, and burst count cnt (width clog2(BURST_MAX+1)).
REQ-016 load_ok SHALL be defined as (!out_valid | out_ready).
REQ-017 In IDLE with arb_en=1 and any fifo_empty bit low: g <= first non-empty port scanning last+1, last+2, ... mod N_PORTS; cnt <= 0; next state is GRANT; no pop occurs in IDLE.
REQ-018 In IDLE with arb_en=0 or all ports empty: the FSM SHALL remain in IDLE.
REQ-019 In GRANT: fifo_r_en[g] = !fifo_empty[g] & load_ok; all other fifo_r_en bits SHALL be 0.
REQ-020 On a pop: out_data <= fifo_rdata[g], out_src <= g, out_valid <= 1, cnt <= cnt+1.
REQ-021 With no pop and out_valid & out_ready: out_valid <= 0, data and src hold.
REQ-022 Full throughput: pop and downstream accept in the same cycle SHALL replace the word with no bubble.
REQ-023 GRANT -> IDLE with last <= g when (a) a pop occurs with cnt == BURST_MAX-1, or (b) fifo_empty[g]=1 in that cycle.
REQ-024 Otherwise, including when stalled by out_ready=0, the FSM SHALL stay in GRANT, and the burst count SHALL not advance.
REQ-025 Arbitration SHALL have one idle bubble cycle between bursts; no port SHALL be granted twice in a row while another port is non-empty at the IDLE cycle.
REQ-026 arb_en falling mid-burst SHALL NOT truncate the burst.
REQ-027 Index wrap: the scan from last = N_PORTS-1 SHALL start at port 0.

Reset
REQ-028 On rst_r low, asynchronously: state=IDLE, g=0, last=N_PORTS-1, cnt=0, out_valid=0, out_data=0, out_src=0, busy=0.
REQ-029 fifo_r_en SHALL be all-zero for as long as rst_r is low, and a word in flight SHALL be discarded.
REQ-030 After rst_r rises, the first grant SHALL go to the lowest-indexed non-empty port.

Verification
REQ-031 Port 2 only holding 3 words (0xA1,0xA2,0xA3), out_ready=1 -> 1 idle cycle, then 3 consecutive pops; out_data A1,A2,A3 with out_src=2; empty ends the burst; back to IDLE.
REQ-032 All 4 ports holding 6 words, BURST_MAX=4, out_ready=1 -> grant order 0,1,2,3,0,1,2,3; bursts 4,4,4,4,2,2,2,2; one bubble between bursts.
REQ-033 Port 1 granted, out_ready low for 5 cycles after the first pop -> fifo_r_en=0 during the stall, out_data holds, cnt stays 1, then 3 more pops resume.
REQ-034 arb_en dropped after the 2nd pop of a 4-word burst -> the remaining 2 words still pop; the FSM returns to IDLE and stays there while arb_en=0.
REQ-035 rst_r asserted mid-burst with out_valid=1 -> same cycle: fifo_r_en=0, out_valid=0; after release, the port 0 grant precedes others.
REQ-036 Checker on all tests: onehot0(fifo_r_en); no fifo_r_en bit high on an empty port; no word lost or duplicated per port (scoreboard).

Source files
------------

// File: rtl/fifo_rd_arbiter_if.sv
// Bundle between the FIFO read sides, the arbiter and the downstream consumer.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface fifo_rd_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 8
);
  localparam int SRC_W = $clog2(N_PORTS);

  logic                       arb_en;
  logic [N_PORTS-1:0]         fifo_empty;
  logic [N_PORTS*DATA_W-1:0]  fifo_rdata;
  logic [N_PORTS-1:0]         fifo_r_en;
  logic [DATA_W-1:0]          out_data;
  logic [SRC_W-1:0]           out_src;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;

  modport master (
    output arb_en, fifo_empty, fifo_rdata, out_ready,
    input  fifo_r_en, out_data, out_src, out_valid, busy
  );

  modport slave (
    input  arb_en, fifo_empty, fifo_rdata, out_ready,
    output fifo_r_en, out_data, out_src, out_valid, busy
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter over N fall-through FIFO read sides, feeding one
// registered valid/ready output stage.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no grant held; picks next non-empty port after `last`
// ST_GRANT | port g owns the output; pops up to BURST_MAX words
module fifo_rd_arbiter #(
  parameter int N_PORTS   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_MAX = 4
) (
  input logic              clk_r,
  input logic              rst_r,
  fifo_rd_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(BURST_MAX + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]         state;
  logic [SRC_W-1:0]   g;
  logic [SRC_W-1:0]   last;
  logic [CNT_W-1:0]   cnt;
  logic [SRC_W-1:0]   next_g;
  logic               any_ready;
  logic [N_PORTS-1:0] r_en;
  logic               load_ok;
  logic               pop;
  logic               burst_done;
  logic [DATA_W-1:0]  out_data_q;
  logic [SRC_W-1:0]   out_src_q;
  logic               out_valid_q;

  // Scan starts one past the last served port so the previous owner comes last.
  always_comb begin
    logic [SRC_W-1:0] idx;
    next_g    = '0;
    any_ready = 1'b0;
    idx       = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      idx = SRC_W'((int'(last) + i) % N_PORTS);
      if (!any_ready && !bus.fifo_empty[idx]) begin
        any_ready = 1'b1;
        next_g    = idx;
      end
    end
  end

  assign load_ok = !out_valid_q || bus.out_ready;

  always_comb begin
    r_en = '0;
    if (state == ST_GRANT && !bus.fifo_empty[g] && load_ok) begin
      r_en[g] = 1'b1;
    end
  end

  assign pop        = |r_en;
  assign burst_done = (pop && cnt == CNT_W'(BURST_MAX - 1)) || bus.fifo_empty[g];

  always_ff @(posedge clk_r or negedge rst_r) begin
    if (!rst_r) begin
      state <= ST_IDLE;
      g     <= '0;
      last  <= SRC_W'(N_PORTS - 1);
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.arb_en && any_ready) begin
            g     <= next_g;
            cnt   <= '0;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (burst_done) begin
            state <= ST_IDLE;
            last  <= g;
          end else if (pop) begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // A pop overwrites the output word even when it is being accepted this cycle.
  always_ff @(posedge clk_r or negedge rst_r) begin
    if (!rst_r) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (pop) begin
      out_data_q  <= bus.fifo_rdata[int'(g)*DATA_W +: DATA_W];
      out_src_q   <= g;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.fifo_r_en = r_en;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state == ST_GRANT);
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: behavioural FIFOs per port, a pop/accept
// scoreboard checked every cycle, and one task per scenario.
module tb_fifo_rd_arbiter;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int BM = 4;

  logic clk_r = 1'b0;
  logic rst_r;
  always #5 clk_r = ~clk_r;

  fifo_rd_arbiter_if #(.N_PORTS(NP), .DATA_W(DW)) bus();

  fifo_rd_arbiter #(.N_PORTS(NP), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk_r (clk_r),
    .rst_r (rst_r),
    .bus   (bus)
  );

  logic [7:0] mem  [NP][16];
  logic [7:0] head [NP];
  logic [7:0] tail [NP];

  for (genvar p = 0; p < NP; p++) begin : g_fifo
    assign bus.fifo_empty[p]          = (head[p] == tail[p]);
    assign bus.fifo_rdata[p*DW +: DW] = mem[p][head[p][3:0]];
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [9:0] sb[$];
  int pop_port[$];
  int pop_cyc[$];

  task automatic push(input int p, input logic [7:0] d);
    mem[p][tail[p][3:0]] = d;
    tail[p] = tail[p] + 8'd1;
  endtask

  // One clock: per-cycle invariants and scoreboard, then advance the FIFO models.
  task automatic tick();
    logic [NP-1:0] en;
    #1;
    en = bus.fifo_r_en;
    tests++;
    if ((en & (en - 1'b1)) !== '0) begin
      fails++; $display("FAIL onehot0 cyc=%0d fifo_r_en=%b required at most one bit", cyc, en);
    end
    tests++;
    if ((en & bus.fifo_empty) !== '0) begin
      fails++; $display("FAIL pop_on_empty cyc=%0d fifo_r_en=%b empty=%b", cyc, en, bus.fifo_empty);
    end
    if (bus.out_valid && bus.out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++; $display("FAIL sb_dup cyc=%0d got src=%0d data=%h required no word", cyc, bus.out_src, bus.out_data);
      end else begin
        if ({bus.out_src, bus.out_data} !== sb[0]) begin
          fails++; $display("FAIL sb_word cyc=%0d got %h required %h", cyc, {bus.out_src, bus.out_data}, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (en[p]) begin
        sb.push_back({2'(p), mem[p][head[p][3:0]]});
        pop_port.push_back(p);
        pop_cyc.push_back(cyc);
      end
    end
    @(posedge clk_r); #1;
    for (int p = 0; p < NP; p++) if (en[p]) head[p] = head[p] + 8'd1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_r = 1'b0;
    bus.arb_en = 1'b0;
    bus.out_ready = 1'b1;
    for (int p = 0; p < NP; p++) tail[p] = head[p];
    sb.delete(); pop_port.delete(); pop_cyc.delete();
    repeat (2) @(posedge clk_r);
    #1 rst_r = 1'b1;
  endtask

  task automatic test_reset();
    rst_r = 1'b0;
    bus.arb_en = 1'b1;
    bus.out_ready = 1'b1;
    push(0, 8'h55);
    #3;
    tests++;
    if (bus.fifo_r_en !== 4'b0000 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_ctl r_en=%b busy=%b valid=%b required 0000/0/0", bus.fifo_r_en, bus.busy, bus.out_valid);
    end
    tests++;
    if (bus.out_data !== 8'h00 || bus.out_src !== 2'd0) begin
      fails++; $display("FAIL reset_data data=%h src=%0d required 00/0", bus.out_data, bus.out_src);
    end
    do_reset();
  endtask

  task automatic test_single_port();
    logic [3:0] exp_en [6];
    logic       exp_busy [6];
    logic       exp_vld [6];
    logic [7:0] exp_dat [6];
    exp_en   = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_vld  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_dat  = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    do_reset();
    push(2, 8'hA1); push(2, 8'hA2); push(2, 8'hA3);
    bus.arb_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests++;
      if (bus.fifo_r_en !== exp_en[i] || bus.busy !== exp_busy[i] || bus.out_valid !== exp_vld[i]) begin
        fails++; $display("FAIL single_ctl i=%0d got en=%b busy=%b vld=%b required en=%b busy=%b vld=%b",
                          i, bus.fifo_r_en, bus.busy, bus.out_valid, exp_en[i], exp_busy[i], exp_vld[i]);
      end
      if (exp_vld[i]) begin
        tests++;
        if (bus.out_data !== exp_dat[i] || bus.out_src !== 2'd2) begin
          fails++; $display("FAIL single_data i=%0d got %h/%0d required %h/2", i, bus.out_data, bus.out_src, exp_dat[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int bp[$]; int bl[$]; int bs[$]; int be[$];
    int exp_p [8];
    int exp_l [8];
    int guard;
    exp_p = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_l = '{4, 4, 4, 4, 2, 2, 2, 2};
    do_reset();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 6; k++) push(p, 8'(16 * p + k));
    bus.arb_en = 1'b1;
    guard = 0;
    while (pop_port.size() < 24 && guard < 300) begin
      tick();
      guard++;
    end
    tests++;
    if (pop_port.size() != 24) begin
      fails++; $display("FAIL rr_timeout pops=%0d required 24", pop_port.size());
    end
    for (int i = 0; i < pop_port.size(); i++) begin
      if (i == 0 || pop_port[i] != pop_port[i-1]) begin
        bp.push_back(pop_port[i]); bl.push_back(1); bs.push_back(pop_cyc[i]); be.push_back(pop_cyc[i]);
      end else begin
        int li;
        li = bl.size() - 1;
        bl[li] = bl[li] + 1;
        be[li] = pop_cyc[i];
      end
    end
    tests++;
    if (bp.size() != 8) begin
      fails++; $display("FAIL rr_bursts got %0d bursts required 8", bp.size());
    end
    for (int k = 0; k < 8 && k < bp.size(); k++) begin
      tests++;
      if (bp[k] != exp_p[k] || bl[k] != exp_l[k]) begin
        fails++; $display("FAIL rr_burst k=%0d got port %0d len %0d required port %0d len %0d", k, bp[k], bl[k], exp_p[k], exp_l[k]);
      end
      if (k < 4 && k + 1 < bp.size()) begin
        tests++;
        if (bs[k+1] - be[k] != 2) begin
          fails++; $display("FAIL rr_bubble k=%0d got gap %0d required 2", k, bs[k+1] - be[k]);
        end
      end
    end
    repeat (4) tick();
    tests++;
    if (sb.size() != 0 || bus.fifo_empty !== 4'hF) begin
      fails++; $display("FAIL rr_drain got sb=%0d empty=%b required 0/1111", sb.size(), bus.fifo_empty);
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 6; k++) push(1, 8'(8'hB0 + k));
    bus.arb_en = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (bus.fifo_r_en !== 4'b0000 || bus.out_data !== 8'hB0 || bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
        fails++; $display("FAIL stall_hold i=%0d got en=%b data=%h vld=%b busy=%b required 0000/b0/1/1",
                          i, bus.fifo_r_en, bus.out_data, bus.out_valid, bus.busy);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (bus.fifo_r_en !== 4'b0010) begin
        fails++; $display("FAIL stall_resume i=%0d got en=%b required 0010", i, bus.fifo_r_en);
      end
      tick();
    end
    #1;
    tests++;
    if (bus.busy !== 1'b0 || pop_port.size() != 4) begin
      fails++; $display("FAIL stall_end got busy=%b pops=%0d required 0/4", bus.busy, pop_port.size());
    end
  endtask

  task automatic test_arb_en_drop();
    do_reset();
    for (int k = 0; k < 6; k++) push(0, 8'(8'hC0 + k));
    bus.arb_en = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) bus.arb_en = 1'b0;
      #1;
      tests++;
      if (bus.fifo_r_en !== 4'b0001) begin
        fails++; $display("FAIL arb_drop_pop i=%0d got en=%b required 0001", i, bus.fifo_r_en);
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (bus.busy !== 1'b0 || bus.fifo_r_en !== 4'b0000) begin
        fails++; $display("FAIL arb_drop_idle i=%0d got busy=%b en=%b required 0/0000", i, bus.busy, bus.fifo_r_en);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) push(1, 8'(8'hD0 + k));
    bus.arb_en = 1'b1;
    tick(); tick(); tick();
    push(0, 8'hE0); push(0, 8'hE1);
    #2 rst_r = 1'b0;
    #1;
    tests++;
    if (bus.fifo_r_en !== 4'b0000 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL rst_mid got en=%b vld=%b busy=%b required 0000/0/0", bus.fifo_r_en, bus.out_valid, bus.busy);
    end
    sb.delete();
    @(posedge clk_r);
    #1 rst_r = 1'b1;
    tick();
    #1;
    tests++;
    if (bus.fifo_r_en !== 4'b0001 || bus.busy !== 1'b1) begin
      fails++; $display("FAIL rst_first_grant got en=%b busy=%b required 0001/1", bus.fifo_r_en, bus.busy);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < NP; p++) begin
      head[p] = 8'd0;
      tail[p] = 8'd0;
    end
    test_reset();
    test_single_port();
    test_round_robin();
    test_stall();
    test_arb_en_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
